mvm_ctrl: RTL and testbench

- Control FSM that sequences the MVM datapath for a MAT_SCALE x MAT_SCALE matrix-vector multiply y = A·x.
- Accepts the loadMatrix / loadVector / start command pulses from the bench-facing interface.
- Drives write strobes and addresses for the matrix and vector memories, read addresses for the MAC issue stream, accumulator control, y-buffer writes, and the output readout phase including `done`.
- Contains no datapath arithmetic; it sits beside the memories and the MAC inside the top-level mvm wrapper.

---
 rtl/mvm_ctrl_pkg.sv | 32 +++
 rtl/mvm_ctrl_if.sv | 53 +++++
 rtl/mvm_ctrl_rc_cnt.sv | 47 ++++
 rtl/mvm_ctrl.sv | 137 +++++++++++++
 tb/tb_mvm_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_ctrl_pkg.sv
// Shared types and width helpers for the MVM control block.
package mvm_pkg;

    localparam int MAT_SCALE_DEF = 8;
    localparam int PIPE_LAT_DEF  = 1;

    // Row field of a pipeline token; wide enough for any practical MAT_SCALE.
    localparam int TOK_ROW_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_V,
        COMPUTE,
        DRAIN,
        OUT
    } state_t;

    // One issued multiply travelling toward the MAC.
    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TOK_ROW_W-1:0] row;
    } token_t;

    // Address width for an n-entry memory, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_ctrl_if.sv
// Command / memory-control bundle between the bench side and mvm_ctrl.
// Optional macro MVM_CTRL_PERF_EN adds the cycles counter output.
//
// Handshake: there is no valid/ready pair. loadMatrix, loadVector and start
// are single-cycle pulses that are only honoured while state == IDLE; a
// pulse in any other state is silently dropped. The master must therefore
// watch state (or done) before issuing the next command.
interface mvm_ctrl_if
    import mvm_pkg::*;
#(
    parameter int MAT_SCALE = MAT_SCALE_DEF
);
    localparam int AW = idx_w(MAT_SCALE);
    localparam int IW = idx_w(MAT_SCALE * MAT_SCALE);

    logic          loadMatrix;
    logic          loadVector;
    logic          start;
    logic          done;
    logic          m_we;
    logic [IW-1:0] m_addr;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic          acc_en;
    logic          acc_clr;
    logic          y_we;
    logic [AW-1:0] y_waddr;
    logic          y_re;
    logic [AW-1:0] y_raddr;
    state_t        state;
`ifdef MVM_CTRL_PERF_EN
    logic [31:0]   cycles;
`endif

    modport master (
        output loadMatrix, loadVector, start,
        input  done, m_we, m_addr, x_we, x_addr, acc_en, acc_clr,
        input  y_we, y_waddr, y_re, y_raddr, state
`ifdef MVM_CTRL_PERF_EN
        , input cycles
`endif
    );

    modport slave (
        input  loadMatrix, loadVector, start,
        output done, m_we, m_addr, x_we, x_addr, acc_en, acc_clr,
        output y_we, y_waddr, y_re, y_raddr, state
`ifdef MVM_CTRL_PERF_EN
        , output cycles
`endif
    );

endinterface

// File: rtl/mvm_ctrl_rc_cnt.sv
// Nested row/column counter with a running linear index. Column is the
// inner loop; both wrap only on an explicit compare against their last value.
module mvm_ctrl_rc_cnt
    import mvm_pkg::*;
#(
    parameter  int ROWS = MAT_SCALE_DEF,
    parameter  int COLS = MAT_SCALE_DEF,
    localparam int RW   = idx_w(ROWS),
    localparam int CW   = idx_w(COLS),
    localparam int IW   = idx_w(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [IW-1:0] idx,
    output logic          col_last,
    output logic          row_last
);

    assign col_last = (col == CW'(COLS - 1));
    assign row_last = (row == RW'(ROWS - 1));

    // Advance column, carry into row, keep the linear index in step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
            idx <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            idx <= (col_last && row_last) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mvm_ctrl.sv
// Control FSM sequencing matrix/vector loads, the MAC issue stream, the
// y-buffer writes and the readout of y = A*x.
// Optional macro MVM_CTRL_PERF_EN adds a start-to-done cycle counter.
module mvm_ctrl
    import mvm_pkg::*;
#(
    parameter int MAT_SCALE = MAT_SCALE_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mvm_ctrl_if.slave  bus
);

    localparam int M  = MAT_SCALE;
    localparam int AW = idx_w(M);
    localparam int IW = idx_w(M * M);

    state_t        state;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [IW-1:0] idx;
    logic          col_last;
    logic          row_last;
    logic          cnt_en;
    logic          cnt_clr;
    logic          mat_end;
    logic          cmd_s;

    token_t        issue_tok;
    token_t        pipe [PIPE_LAT];
    token_t        pipe_out;
    logic          y_we_q;
    logic [AW-1:0] y_waddr_q;

    // loadMatrix wins over loadVector, which wins over start.
    assign cmd_s = bus.start & ~bus.loadMatrix & ~bus.loadVector;

    assign mat_end = col_last && row_last;
    assign cnt_en  = (state == LOAD_M) || (state == LOAD_V) ||
                     (state == COMPUTE) || (state == OUT);
    // Single-row phases clear explicitly so the row never advances.
    assign cnt_clr = ((state == LOAD_V) || (state == OUT)) && col_last;

    mvm_ctrl_rc_cnt #(
        .ROWS (M),
        .COLS (M)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .row      (row),
        .col      (col),
        .idx      (idx),
        .col_last (col_last),
        .row_last (row_last)
    );

    // Phase sequencing; commands are only looked at in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.loadMatrix)      state <= LOAD_M;
                    else if (bus.loadVector) state <= LOAD_V;
                    else if (cmd_s)          state <= COMPUTE;
                end
                LOAD_M:  if (mat_end)  state <= IDLE;
                LOAD_V:  if (col_last) state <= IDLE;
                COMPUTE: if (mat_end)  state <= DRAIN;
                // The row M-1 write is the final accumulator result.
                DRAIN:   if (y_we_q && (y_waddr_q == AW'(M - 1))) state <= OUT;
                OUT:     if (col_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Token describing the multiply issued this cycle.
    always_comb begin
        issue_tok       = '0;
        issue_tok.valid = (state == COMPUTE);
        issue_tok.first = (state == COMPUTE) && (col == '0);
        issue_tok.last  = (state == COMPUTE) && col_last;
        issue_tok.row   = TOK_ROW_W'(row);
    end

    assign pipe_out = pipe[PIPE_LAT-1];

    // Delay tokens by the memory read latency, then flag the y write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
            y_we_q    <= 1'b0;
            y_waddr_q <= '0;
        end else begin
            pipe[0] <= issue_tok;
            for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
            y_we_q    <= pipe_out.valid & pipe_out.last;
            y_waddr_q <= AW'(pipe_out.row);
        end
    end

    assign bus.state   = state;
    assign bus.m_we    = (state == LOAD_M);
    assign bus.m_addr  = ((state == LOAD_M) || (state == COMPUTE)) ? idx : '0;
    assign bus.x_we    = (state == LOAD_V);
    assign bus.x_addr  = ((state == LOAD_V) || (state == COMPUTE)) ? col : '0;
    assign bus.acc_en  = pipe_out.valid;
    assign bus.acc_clr = pipe_out.valid & pipe_out.first;
    assign bus.y_we    = y_we_q;
    assign bus.y_waddr = y_waddr_q;
    assign bus.y_re    = (state == OUT);
    assign bus.y_raddr = (state == OUT) ? col : '0;
    assign bus.done    = (state == OUT) && (col == '0);

`ifdef MVM_CTRL_PERF_EN
    logic [31:0] cycles_q;

    // Count busy cycles between start acceptance and done, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if ((state == IDLE) && cmd_s) begin
            cycles_q <= '0;
        end else if (((state == COMPUTE) || (state == DRAIN)) && (cycles_q != '1)) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end

    assign bus.cycles = cycles_q;
`endif

endmodule

// File: tb/tb_mvm_ctrl.sv
// Bench for mvm_ctrl: table of command records plus hand-written corner
// sequences, with a small memory/MAC datapath and a y = A*x reference.
module tb_mvm_ctrl;
    import mvm_pkg::*;

    localparam int M = 8;
    localparam int P = 1;
    localparam int D = M * M + P + 2;   // done offset after the start cycle

    logic clk;
    logic reset;
    logic [7:0] data_in;

    mvm_ctrl_if #(.MAT_SCALE(M)) bus ();

    mvm_ctrl #(.MAT_SCALE(M), .PIPE_LAT(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath around the controller: memories, MAC, y buffer.
    logic [7:0]  a_mem [M*M];
    logic [7:0]  x_mem [M];
    logic [31:0] y_mem [M];
    logic [7:0]  a_q, x_q;
    logic [31:0] acc, data_out;

    always @(posedge clk) begin
        if (bus.m_we) a_mem[bus.m_addr] <= data_in;
        if (bus.x_we) x_mem[bus.x_addr] <= data_in;
        a_q <= a_mem[bus.m_addr];
        x_q <= x_mem[bus.x_addr];
        if (bus.acc_en) acc <= bus.acc_clr ? 32'(a_q) * 32'(x_q) : acc + 32'(a_q) * 32'(x_q);
        if (bus.y_we) y_mem[bus.y_waddr] <= acc;
        if (bus.y_re) data_out <= y_mem[bus.y_raddr];
    end

    // Reference model: what was loaded, and the resulting product.
    int unsigned a_ref [M*M];
    int unsigned x_ref [M];
    longint      y_ref [M];
    logic [7:0]  plan_a [M*M];
    logic [7:0]  plan_x [M];

    int checks = 0;
    int errors = 0;

    // Observations from the last command run.
    int mwe_n, mwe_bad, xwe_n, xwe_bad, done_at, done_n, clr_n, yre_n, yre_bad, idle_at;
    longint perf_at_done;
    logic [31:0] got_y [M];
    logic [31:0] first_y [M];

    typedef struct {
        logic lm;
        logic lv;
        logic st;
        int   kind;        // 0 none, 1 identity A, 2 random A, 3 x=1..M, 4 random x
        int   noise_until; // random commands driven before this cycle
        int   linger;      // idle cycles observed after returning to IDLE
        int   exp_mwe;
        int   exp_xwe;
        int   exp_done;
        int   exp_idle;
        int   exp_clr;
    } vec_t;

    vec_t tbl [7];
    vec_t st_v;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic plan(input int kind);
        for (int i = 0; i < M * M; i++) begin
            if (kind == 1) plan_a[i] = ((i / M) == (i % M)) ? 8'd1 : 8'd0;
            else           plan_a[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < M; i++) begin
            if (kind == 3) plan_x[i] = 8'(i + 1);
            else           plan_x[i] = 8'($urandom_range(0, 255));
        end
    endtask

    function automatic void commit(input vec_t v);
        if (v.exp_mwe == M * M) for (int i = 0; i < M * M; i++) a_ref[i] = plan_a[i];
        if (v.exp_xwe == M)     for (int i = 0; i < M; i++)     x_ref[i] = plan_x[i];
        for (int r = 0; r < M; r++) begin
            y_ref[r] = 0;
            for (int c = 0; c < M; c++) y_ref[r] += longint'(a_ref[r*M+c]) * longint'(x_ref[c]);
        end
    endfunction

    // Issue one command in the current cycle and observe until back in IDLE.
    task automatic do_cmd(input logic lm, input logic lv, input logic st, input int kind,
                          input int noise_until, input int inj_at, input int linger,
                          input int budget);
        mwe_n = 0; mwe_bad = 0; xwe_n = 0; xwe_bad = 0; done_at = -1; done_n = 0;
        clr_n = 0; yre_n = 0; yre_bad = 0; idle_at = -1; perf_at_done = -1;
        for (int j = 0; j < M; j++) got_y[j] = '0;
        bus.loadMatrix = lm;
        bus.loadVector = lv;
        bus.start      = st;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c < noise_until) begin
                bus.loadMatrix = 1'($urandom_range(0, 1));
                bus.loadVector = 1'($urandom_range(0, 1));
                bus.start      = 1'($urandom_range(0, 1));
            end else begin
                bus.loadMatrix = 1'b0;
                bus.loadVector = 1'b0;
                bus.start      = 1'b0;
            end
            if (c == inj_at) bus.loadMatrix = 1'b1;
            data_in = 8'($urandom_range(0, 255));
            if ((kind == 1 || kind == 2) && (c - 1 < M * M)) data_in = plan_a[c-1];
            if ((kind == 3 || kind == 4) && (c - 1 < M))     data_in = plan_x[c-1];
            if (bus.m_we) begin
                if (int'(bus.m_addr) != mwe_n || c != mwe_n + 1) mwe_bad++;
                mwe_n++;
            end
            if (bus.x_we) begin
                if (int'(bus.x_addr) != xwe_n || c != xwe_n + 1) xwe_bad++;
                xwe_n++;
            end
            if (bus.acc_en && bus.acc_clr) clr_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = c;
`ifdef MVM_CTRL_PERF_EN
                    perf_at_done = longint'(bus.cycles);
`endif
                end
            end
            if (bus.y_re) begin
                if (done_at < 0 || int'(bus.y_raddr) != yre_n || c != done_at + yre_n) yre_bad++;
                yre_n++;
            end
            if (done_at >= 0 && c > done_at && c <= done_at + M) got_y[c-done_at-1] = data_out;
            if (bus.state == IDLE && idle_at < 0) idle_at = c;
            if (idle_at >= 0 && c >= idle_at + linger) break;
        end
    endtask

    task automatic check_entry(input string tag, input vec_t v);
        chk({tag, ".m_we_cnt"}, mwe_n, v.exp_mwe);
        chk({tag, ".m_addr_seq_bad"}, mwe_bad, 0);
        chk({tag, ".x_we_cnt"}, xwe_n, v.exp_xwe);
        chk({tag, ".x_addr_seq_bad"}, xwe_bad, 0);
        chk({tag, ".done_at"}, done_at, v.exp_done);
        chk({tag, ".done_cnt"}, done_n, (v.exp_done >= 0) ? 1 : 0);
        chk({tag, ".idle_at"}, idle_at, v.exp_idle);
        chk({tag, ".acc_clr_cnt"}, clr_n, v.exp_clr);
        if (v.exp_done >= 0) begin
            chk({tag, ".y_re_cnt"}, yre_n, M);
            chk({tag, ".y_raddr_seq_bad"}, yre_bad, 0);
            for (int j = 0; j < M; j++)
                chk($sformatf("%s.y[%0d]", tag, j), longint'(got_y[j]), y_ref[j]);
        end
    endtask

    function automatic longint outs_vec();
        return longint'({bus.m_we, bus.m_addr, bus.x_we, bus.x_addr, bus.acc_en, bus.acc_clr,
                         bus.y_we, bus.y_waddr, bus.y_re, bus.y_raddr, bus.done});
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                lm    lv    st  kind noise linger mwe xwe done idle clr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1, 65, 0,  64, 0, -1, 65, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 3, 9,  0,  0,  8, -1, 9,  0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 3, 0,  80, 0,  8, -1, 9,  0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 0, 75, 0,  0,  0, D,  75, 8};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 2, 0,  0,  64, 0, -1, 65, 0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4, 9,  0,  0,  8, -1, 9,  0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 0, 75, 0,  0,  0, D,  75, 8};
        st_v   = '{1'b0, 1'b0, 1'b1, 0, 0,  0,  0,  0, D,  75, 8};

        for (int i = 0; i < M * M; i++) a_ref[i] = 0;
        for (int i = 0; i < M; i++)     x_ref[i] = 0;

        reset = 1'b1;
        bus.loadMatrix = 1'b0;
        bus.loadVector = 1'b0;
        bus.start      = 1'b0;
        data_in = 8'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.outputs", outs_vec(), 0);
        chk("reset.state", longint'(bus.state), longint'(IDLE));
        reset = 1'b0;

        // Table-driven commands, each issued in the cycle the previous ended.
        for (int t = 0; t < 7; t++) begin
            plan(tbl[t].kind);
            do_cmd(tbl[t].lm, tbl[t].lv, tbl[t].st, tbl[t].kind, tbl[t].noise_until,
                   0, tbl[t].linger, 200);
            commit(tbl[t]);
            check_entry($sformatf("tbl%0d", t), tbl[t]);
        end

        // loadMatrix pulsed mid-compute must not disturb memory or result.
        do_cmd(1'b0, 1'b0, 1'b1, 0, 0, 10, 0, 200);
        commit(st_v);
        check_entry("inj_lm", st_v);

        // Asynchronous reset at compute issue cycle 20, then a clean start.
        bus.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("rst_mid.pre_state", longint'(bus.state), longint'(COMPUTE));
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.outputs", outs_vec(), 0);
        chk("rst_mid.state", longint'(bus.state), longint'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        do_cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 200);
        check_entry("after_rst", st_v);

        // Back-to-back starts: second issued in the first IDLE cycle after OUT.
        do_cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 200);
        check_entry("b2b_first", st_v);
        for (int j = 0; j < M; j++) first_y[j] = got_y[j];
`ifdef MVM_CTRL_PERF_EN
        chk("b2b_first.cycles", perf_at_done, 66);
`endif
        do_cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 200);
        check_entry("b2b_second", st_v);
        for (int j = 0; j < M; j++)
            chk($sformatf("b2b.same_y[%0d]", j), longint'(got_y[j]), longint'(first_y[j]));
`ifdef MVM_CTRL_PERF_EN
        chk("b2b_second.cycles", perf_at_done, 66);
`endif

        // Random matrices and vectors against the reference product.
        for (int r = 0; r < 3; r++) begin
            plan(2);
            do_cmd(1'b1, 1'b0, 1'b0, 2, 65, 0, 0, 200);
            commit(tbl[0]);
            check_entry($sformatf("rnd%0d.ld_m", r), tbl[0]);
            plan(4);
            do_cmd(1'b0, 1'b1, 1'b0, 4, 9, 0, 0, 200);
            commit(tbl[5]);
            check_entry($sformatf("rnd%0d.ld_v", r), tbl[5]);
            do_cmd(1'b0, 1'b0, 1'b1, 0, 75, 0, 0, 200);
            commit(st_v);
            check_entry($sformatf("rnd%0d.start", r), st_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
